// File: rtl/mc_ctrl_if.sv
// Control bundle between the mips IR/ALU and the main controller.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [3:0] status;
  logic       pc_we;
  logic       ir_we;
  logic [1:0] npc_sel;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic [1:0] ext_op;
  logic       alu_src_b;
  logic [2:0] alu_op;
  logic       dm_we;

  // Controller side: consumes instruction fields and flags, drives datapath controls.
  modport master (
    input  op, funct, zero, overflow,
    output status, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
           ext_op, alu_src_b, alu_op, dm_we
  );

  // Datapath side.
  modport slave (
    output op, funct, zero, overflow,
    input  status, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
           ext_op, alu_src_b, alu_op, dm_we
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the mips core: decodes op/funct and
// sequences fetch/decode/execute/memory/writeback.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
    S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
    S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_LW, I_SW, I_ADDU, I_SUBU, I_SLT, I_BEQ,
    I_J, I_JAL, I_JR, I_ORI, I_LUI, I_ADDI, I_ADDIU
  } instr_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  state_t     state, state_nx;
  instr_t     instr;

  logic       pc_we, ir_we, reg_we, alu_src_b, dm_we;
  logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0] alu_op;

  // Instruction decode from the registered IR fields; anything unknown is a nop.
  always_comb begin
    instr = I_NOP;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h2a:   instr = I_SLT;
          6'h08:   instr = I_JR;
          default: instr = I_NOP;
        endcase
      end
      6'h23:   instr = I_LW;
      6'h2b:   instr = I_SW;
      6'h04:   instr = I_BEQ;
      6'h02:   instr = I_J;
      6'h03:   instr = I_JAL;
      6'h0d:   instr = I_ORI;
      6'h0f:   instr = I_LUI;
      6'h08:   instr = I_ADDI;
      6'h09:   instr = I_ADDIU;
      default: instr = I_NOP;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S0;
    else      state <= state_nx;
  end

  // Next-state and Moore-plus-decode outputs; all outputs forced low while in reset.
  always_comb begin
    state_nx  = S0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    npc_sel   = 2'd0;
    reg_we    = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    ext_op    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    dm_we     = 1'b0;
    if (rst) begin
      case (state)
        S0: begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = S1;
        end
        S1: begin
          case (instr)
            I_LW, I_SW:                    state_nx = S2;
            I_ADDU, I_SUBU, I_SLT:         state_nx = S6;
            I_BEQ:                         state_nx = S8;
            I_J, I_JAL, I_JR:              state_nx = S9;
            I_ORI, I_LUI, I_ADDI, I_ADDIU: state_nx = S10;
            default:                       state_nx = S0;
          endcase
        end
        S2: begin
          alu_src_b = 1'b1;
          ext_op    = 2'd1;
          alu_op    = ALU_ADD;
          state_nx  = (instr == I_SW) ? S5 : S3;
        end
        S3: state_nx = S4;
        S4: begin
          reg_we  = 1'b1;
          reg_dst = 2'd0;
          wd_sel  = 2'd1;
        end
        S5: dm_we = 1'b1;
        S6: begin
          case (instr)
            I_SUBU:  alu_op = ALU_SUB;
            I_SLT:   alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          state_nx = S7;
        end
        S7: begin
          reg_we  = 1'b1;
          reg_dst = 2'd1;
          wd_sel  = 2'd0;
        end
        S8: begin
          alu_op  = ALU_SUB;
          ext_op  = 2'd1;
          pc_we   = bus.zero;
          npc_sel = 2'd1;
        end
        S9: begin
          pc_we = 1'b1;
          case (instr)
            I_JAL: begin
              npc_sel = 2'd2;
              reg_we  = 1'b1;
              reg_dst = 2'd2;
              wd_sel  = 2'd2;
            end
            I_JR:    npc_sel = 2'd3;
            default: npc_sel = 2'd2;
          endcase
        end
        S10: begin
          alu_src_b = 1'b1;
          case (instr)
            I_ORI: begin
              ext_op = 2'd0;
              alu_op = ALU_OR;
            end
            I_LUI: begin
              ext_op = 2'd2;
              alu_op = ALU_OR;
            end
            default: begin
              ext_op = 2'd1;
              alu_op = ALU_ADD;
            end
          endcase
          state_nx = S11;
        end
        S11: begin
          reg_we = 1'b1;
          if (instr == I_ADDI && bus.overflow) begin
            reg_dst = 2'd3;
            wd_sel  = 2'd3;
          end
        end
        default: state_nx = S0;
      endcase
    end
  end

  assign bus.status    = state;
  assign bus.pc_we     = pc_we;
  assign bus.ir_we     = ir_we;
  assign bus.npc_sel   = npc_sel;
  assign bus.reg_we    = reg_we;
  assign bus.reg_dst   = reg_dst;
  assign bus.wd_sel    = wd_sel;
  assign bus.ext_op    = ext_op;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_op    = alu_op;
  assign bus.dm_we     = dm_we;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: traces each instruction class state by state.
module tb_mc_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word: status,pc_we,ir_we,npc_sel,reg_we,reg_dst,wd_sel,ext_op,alu_src_b,alu_op,dm_we
  function automatic logic [19:0] obs();
    return {bus.status, bus.pc_we, bus.ir_we, bus.npc_sel, bus.reg_we, bus.reg_dst,
            bus.wd_sel, bus.ext_op, bus.alu_src_b, bus.alu_op, bus.dm_we};
  endfunction

  function automatic logic [19:0] pack(input logic [3:0] st, input logic pc, input logic ir,
                                       input logic [1:0] npc, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] wd,
                                       input logic [1:0] ext, input logic asb,
                                       input logic [2:0] aop, input logic dm);
    return {st, pc, ir, npc, rw, rd, wd, ext, asb, aop, dm};
  endfunction

  logic [19:0] v_s0, v_s1, v_zero;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0; bus.overflow = 1'b0;
    #2;
    vectors++;
    if (obs() !== v_zero) begin
      miscompares++;
      $display("FAIL reset_init: got %h want %h", obs(), v_zero);
    end
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== v_s0) begin
      miscompares++;
      $display("FAIL reset_release_s0: got %h want %h", obs(), v_s0);
    end
    step(); step(); step();
    vectors++;
    if (obs() !== pack(4'd7, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 0, 3'd0, 0)) begin
      miscompares++;
      $display("FAIL reset_pre_s7: got %h want S7 word", obs());
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.status !== 4'd0 || bus.reg_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_s7: got status=%0d reg_we=%b want status=0 reg_we=0", bus.status, bus.reg_we);
    end
    step();
    vectors++;
    if (obs() !== v_zero) begin
      miscompares++;
      $display("FAIL reset_held: got %h want %h", obs(), v_zero);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== v_s0) begin
      miscompares++;
      $display("FAIL reset_rel2_s0: got %h want %h", obs(), v_s0);
    end
    step();
    vectors++;
    if (obs() !== v_s1) begin
      miscompares++;
      $display("FAIL reset_rel2_s1: got %h want %h", obs(), v_s1);
    end
    bus.funct = 6'h00;
    step();
    vectors++;
    if (obs() !== v_s0) begin
      miscompares++;
      $display("FAIL reset_nop_return: got %h want %h", obs(), v_s0);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [3];
    logic [2:0] ao [3];
    logic [19:0] exp_q [$];
    fn = '{6'h21, 6'h23, 6'h2a};
    ao = '{3'd0, 3'd1, 3'd3};
    for (int k = 0; k < 3; k++) begin
      bus.op = 6'h00; bus.funct = fn[k]; bus.overflow = 1'b1; bus.zero = 1'b1;
      exp_q = {v_s0, v_s1,
               pack(4'd6, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, ao[k], 0),
               pack(4'd7, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 0, 3'd0, 0),
               v_s0};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) step();
        vectors++;
        if (obs() !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rtype_f%h_c%0d: got %h want %h", fn[k], i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [19:0] exp_q [$];
    logic [19:0] s2;
    s2 = pack(4'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 1, 3'd0, 0);
    bus.op = 6'h23; bus.funct = 6'h15; bus.overflow = 1'b0; bus.zero = 1'b0;
    exp_q = {v_s0, v_s1, s2,
             pack(4'd3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0),
             pack(4'd4, 0, 0, 2'd0, 1, 2'd0, 2'd1, 2'd0, 0, 3'd0, 0),
             v_s0};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      vectors++;
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL lw_c%0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
    bus.op = 6'h2b;
    exp_q = {v_s0, v_s1, s2,
             pack(4'd5, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 1),
             v_s0};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      vectors++;
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sw_c%0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [19:0] exp_q [$];
    for (int z = 1; z >= 0; z--) begin
      bus.op = 6'h04; bus.funct = 6'h00; bus.zero = z[0]; bus.overflow = 1'b1;
      exp_q = {v_s0, v_s1,
               pack(4'd8, z[0], 0, 2'd1, 0, 2'd0, 2'd0, 2'd1, 0, 3'd1, 0),
               v_s0};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) step();
        vectors++;
        if (obs() !== exp_q[i]) begin
          miscompares++;
          $display("FAIL beq_z%0d_c%0d: got %h want %h", z, i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [5:0]  ops [3];
    logic [5:0]  fns [3];
    logic [19:0] s9  [3];
    logic [19:0] exp_q [$];
    ops = '{6'h02, 6'h03, 6'h00};
    fns = '{6'h08, 6'h00, 6'h08};
    s9  = '{pack(4'd9, 1, 0, 2'd2, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0),
            pack(4'd9, 1, 0, 2'd2, 1, 2'd2, 2'd2, 2'd0, 0, 3'd0, 0),
            pack(4'd9, 1, 0, 2'd3, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0)};
    for (int k = 0; k < 3; k++) begin
      bus.op = ops[k]; bus.funct = fns[k]; bus.zero = 1'b0; bus.overflow = 1'b0;
      exp_q = {v_s0, v_s1, s9[k], v_s0};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) step();
        vectors++;
        if (obs() !== exp_q[i]) begin
          miscompares++;
          $display("FAIL jump_op%h_c%0d: got %h want %h", ops[k], i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  ops [5];
    logic        ovf [5];
    logic [19:0] s10 [5];
    logic [19:0] s11 [5];
    logic [19:0] exp_q [$];
    ops = '{6'h0d, 6'h0f, 6'h08, 6'h08, 6'h09};
    ovf = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    s10 = '{pack(4'd10, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 3'd2, 0),
            pack(4'd10, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd2, 1, 3'd2, 0),
            pack(4'd10, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 1, 3'd0, 0),
            pack(4'd10, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 1, 3'd0, 0),
            pack(4'd10, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 1, 3'd0, 0)};
    s11 = '{pack(4'd11, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0),
            pack(4'd11, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0),
            pack(4'd11, 0, 0, 2'd0, 1, 2'd3, 2'd3, 2'd0, 0, 3'd0, 0),
            pack(4'd11, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0),
            pack(4'd11, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0)};
    for (int k = 0; k < 5; k++) begin
      bus.op = ops[k]; bus.funct = 6'h21; bus.zero = 1'b1; bus.overflow = ovf[k];
      exp_q = {v_s0, v_s1, s10[k], s11[k], v_s0};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) step();
        vectors++;
        if (obs() !== exp_q[i]) begin
          miscompares++;
          $display("FAIL itype_op%h_ov%b_c%0d: got %h want %h", ops[k], ovf[k], i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_nop_illegal();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops = '{6'h00, 6'h3f, 6'h00};
    fns = '{6'h00, 6'h21, 6'h3f};
    for (int k = 0; k < 3; k++) begin
      bus.op = ops[k]; bus.funct = fns[k]; bus.zero = 1'b1; bus.overflow = 1'b1;
      vectors++;
      if (obs() !== v_s0) begin
        miscompares++;
        $display("FAIL nop%0d_s0: got %h want %h", k, obs(), v_s0);
      end
      step();
      vectors++;
      if (obs() !== v_s1) begin
        miscompares++;
        $display("FAIL nop%0d_s1: got %h want %h", k, obs(), v_s1);
      end
      step();
      vectors++;
      if (obs() !== v_s0) begin
        miscompares++;
        $display("FAIL nop%0d_ret: got %h want %h", k, obs(), v_s0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_q [$];
    // lw immediately followed by jal: IR fields switch while the controller sits in S0.
    bus.op = 6'h23; bus.funct = 6'h00; bus.zero = 1'b0; bus.overflow = 1'b0;
    step(); step(); step(); step(); step();
    bus.op = 6'h03;
    exp_q = {v_s0, v_s1,
             pack(4'd9, 1, 0, 2'd2, 1, 2'd2, 2'd2, 2'd0, 0, 3'd0, 0),
             v_s0};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      vectors++;
      if (obs() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_c%0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    v_s0   = pack(4'd0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0);
    v_s1   = pack(4'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0);
    v_zero = '0;
    test_reset();
    test_rtype();
    test_mem();
    test_beq();
    test_jump();
    test_itype();
    test_nop_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the `mips` core. It decodes the registered instruction (op/funct) and ALU flags, and sequences fetch/decode/execute/memory/writeback states. It drives every datapath enable and mux select, plus the `status` vector that benches poll for instruction completion. It sits between the IR and the datapath (ifu/gpr/alu/dm) and is instantiated inside `mips` as the control unit.

Parameters:
STATE_W, 4, width of status encoding
S0..S11, 4'd0..4'd11, state codes (S0 fetch, S1 decode)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
op  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU A==B
overflow  in  1  ALU signed-add overflow
status  out  4  current state
pc_we  out  1  PC write enable
ir_we  out  1  IR write enable
npc_sel  out  2  0 PC+4, 1 branch, 2 jump (instr_index), 3 jr (rs)
reg_we  out  1  GPR write enable
reg_dst  out  2  0 rt, 1 rd, 2 $31, 3 $30
wd_sel  out  2  0 ALU result, 1 DM data, 2 PC (already +4), 3 constant 1
ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
alu_src_b  out  1  0 rt, 1 extended imm
alu_op  out  3  0 add, 1 sub, 2 or, 3 slt (signed)
dm_we  out  1  data memory write enable

Behaviour:
- Reset (rst=0, async): state=S0. All enables (pc_we, ir_we, reg_we, dm_we) are 0. All selects are 0. On the first edge after release, S0 executes.
- Outputs are a Moore function of state plus the decoded op/funct. overflow and zero are sampled only in the states that name them. Unlisted outputs are 0.
- S0 fetch: ir_we=1, pc_we=1, npc_sel=0. Next state is S1.
- S1 decode: no enables. Next state by instruction:
  - lw/sw → S2
  - addu/subu/slt → S6
  - beq → S8
  - j/jal/jr → S9
  - ori/lui/addi/addiu → S10
  - nop (all-zero word, op=0 funct=0) or any undecoded op/funct → S0 (no side effects)
- S2 address: alu_src_b=1, ext_op=1, alu_op=add. lw → S3, sw → S5.
- S3 mem read: next state S4.
- S4 load WB: reg_we=1, reg_dst=0, wd_sel=1. Next state S0.
- S5 mem write: dm_we=1. Next state S0.
- S6 R-exec: alu_op from funct (addu→add, subu→sub, slt→slt). Next state S7.
- S7 R-WB: reg_we=1, reg_dst=1, wd_sel=0. Next state S0.
- S8 beq: alu_op=sub, ext_op=1. pc_we=zero, npc_sel=1 (target = PC+4 + sext(imm)<<2). Next state S0.
- S9 jump: pc_we=1.
  - j: npc_sel=2.
  - jal: npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2 (PC+4).
  - jr: npc_sel=3.
  - Next state S0.
- S10 I-exec: alu_src_b=1.
  - ori: ext_op=0, alu_op=or.
  - lui: ext_op=2, alu_op=or with $0 (rs field 0).
  - addi/addiu: ext_op=1, alu_op=add.
  - Next state S11.
- S11 I-WB: reg_we=1, wd_sel=0, reg_dst=0.
  - Exception: addi with overflow=1 → reg_dst=3, wd_sel=3 ($30←1, rt untouched).
  - addiu ignores overflow.
  - Next state S0.
- Cycle counts from S0 to the next S0: lw 5; R-type, sw and I-type 4; beq, j, jal, jr 3; nop and illegal 2.
- rst asserted in any state aborts immediately: next state S0, enables drop combinationally with state, no partial write is issued.
- The status encoding is stable. `status==S1` marks "previous instruction retired, next one decoded".

Test Plan:
- Reset: hold rst=0 mid-S7 → status=0 and reg_we=0 immediately. Release → S0 with ir_we=pc_we=1, then S1.
- addu (op=0, funct=0x21): trace S0→S1→S6→S7→S0. In S7, reg_we=1, reg_dst=1, wd_sel=0. slt (funct=0x2a) gives alu_op=3.
- lw (op=0x23): trace S0→S1→S2→S3→S4→S0, with wd_sel=1 in S4. sw (op=0x2b): S5 has dm_we=1 and reg_we=0 throughout.
- beq (op=0x04): zero=1 → S8 has pc_we=1, npc_sel=1. zero=0 → pc_we=0 in S8. Both return to S0 after 3 cycles.
- addi (op=0x08), overflow=1 in S11 → reg_dst=3, wd_sel=3. overflow=0 → reg_dst=0, wd_sel=0. addiu (op=0x09) with overflow=1 → reg_dst=0.
- jal (op=0x03): S9 has pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2. jr (op=0, funct=0x08): npc_sel=3, reg_we=0. nop: S0→S1→S0.
